receive_slot_scheduler: RTL

Controller for the receive queue slots of one RGMII port. It owns the per-slot lifecycle FREE → FILLING → READY → DRAINING → FREE. It drives the one-hot slot enable into the Ethernet packet parser and retires slots on the parser's good/bad packet pulses. It hands completed packets to the switch fabric one slot at a time with round-robin fairness. It sits between the parser (write side) and the forwarding logic (read side), in the parser clock domain.

---
 rtl/receive_slot_scheduler.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/receive_slot_scheduler.sv
// ---------------------------------------------------------------------------
// ReceiveSlotScheduler (module receive_slot_scheduler)
//
// Purpose:
//   Owns the lifecycle of the receive queue slots of one RGMII port.
//   Each slot moves FREE -> FILLING -> READY -> DRAINING -> FREE.
//   The scheduler grants one FREE slot at a time to the packet parser for
//   writing, and retires that slot on the parser's good/bad pulse.
//   It offers READY slots to the switch fabric one at a time with
//   round-robin fairness, and frees slots when the fabric releases them.
//   All logic lives in the parser clock domain.
//
// Parameters:
//   RECEIVE_QUE_SLOTS   number of receive slots (1..16)
//   SLOT_INDEX_WIDTH    derived index width, max(1, clog2(slots))
//
// Ports:
//   clock                 sole clock, rising edge
//   reset                 synchronous active-high reset
//   enable                permits allocation of new slots to the parser
//   good_packet[N]        per-slot pulse: frame finished with good CRC
//   bad_packet[N]         per-slot pulse: frame finished with an error
//   recieve_slot_enable   one-hot (or zero) slot currently being written
//   slot_valid            a READY slot is offered to the fabric
//   slot_index            index of the offered slot
//   slot_ready            fabric accepts the offered slot
//   slot_release          pulse: fabric finished reading release_index
//   release_index         slot being released
//   no_slot_available     enabled, but nothing FILLING and nothing FREE
//   release_error         sticky flag for an illegal release
//   good_packet_count     saturating count of accepted good packets
//   dropped_packet_count  saturating count of discarded bad packets
// ---------------------------------------------------------------------------
module receive_slot_scheduler #(
    parameter int RECEIVE_QUE_SLOTS = 4,
    localparam int SLOT_INDEX_WIDTH =
        (RECEIVE_QUE_SLOTS > 1) ? $clog2(RECEIVE_QUE_SLOTS) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [RECEIVE_QUE_SLOTS-1:0] good_packet,
    input  logic [RECEIVE_QUE_SLOTS-1:0] bad_packet,
    output logic [RECEIVE_QUE_SLOTS-1:0] recieve_slot_enable,
    output logic                         slot_valid,
    output logic [SLOT_INDEX_WIDTH-1:0]  slot_index,
    input  logic                         slot_ready,
    input  logic                         slot_release,
    input  logic [SLOT_INDEX_WIDTH-1:0]  release_index,
    output logic                         no_slot_available,
    output logic                         release_error,
    output logic [15:0]                  good_packet_count,
    output logic [15:0]                  dropped_packet_count
);

    localparam int N  = RECEIVE_QUE_SLOTS;
    localparam int IW = SLOT_INDEX_WIDTH;

    typedef enum logic [1:0] {
        SLOT_FREE     = 2'd0,
        SLOT_FILLING  = 2'd1,
        SLOT_READY    = 2'd2,
        SLOT_DRAINING = 2'd3
    } slotState_e;

    slotState_e        slotState_q [N];
    slotState_e        slotState_d [N];

    logic [IW-1:0]     allocPointer_q, allocPointer_d;
    logic [IW-1:0]     grantPointer_q, grantPointer_d;
    logic [IW-1:0]     slotIndex_q,    slotIndex_d;
    logic              slotValid_q,    slotValid_d;
    logic              releaseError_q, releaseError_d;
    logic              noSlot_q,       noSlot_d;
    logic [N-1:0]      rxEnable_q,     rxEnable_d;
    logic [15:0]       goodCount_q;
    logic [15:0]       dropCount_q;

    logic [N-1:0]      freeMask;
    logic [N-1:0]      readyMask;
    logic [N-1:0]      fillingMask;
    logic [N-1:0]      freeNextMask;
    logic [IW:0]       allocScan;
    logic [IW:0]       readyScan;
    logic              goodInc;
    logic              dropInc;

    // Round-robin search: returns {found, index} of the first set mask bit
    // at or after 'start', wrapping modulo N. Scanning from the far end
    // backwards lets the nearest candidate overwrite the others.
    function automatic logic [IW:0] scanFrom(input logic [IW-1:0] start,
                                             input logic [N-1:0]  mask);
        logic [IW:0] result;
        int          idx;
        result = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(start) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (mask[idx]) begin
                result = {1'b1, IW'(idx)};
            end
        end
        return result;
    endfunction

    // (index + 1) mod N, valid for any N, not only powers of two.
    function automatic logic [IW-1:0] wrapNext(input logic [IW-1:0] idx);
        int n;
        n = int'(idx) + 1;
        if (n >= N) begin
            n = 0;
        end
        return IW'(n);
    endfunction

    function automatic logic [15:0] satInc(input logic [15:0] value,
                                           input logic        inc);
        return (inc && (value != 16'hFFFF)) ? value + 16'd1 : value;
    endfunction

    // Per-slot classification of the registered state; every decision in
    // this cycle is taken from these, never from the next-state values.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            freeMask[i]    = (slotState_q[i] == SLOT_FREE);
            readyMask[i]   = (slotState_q[i] == SLOT_READY);
            fillingMask[i] = (slotState_q[i] == SLOT_FILLING);
        end
    end

    assign allocScan = scanFrom(allocPointer_q, freeMask);
    assign readyScan = scanFrom(grantPointer_q, readyMask);

    // Next-state logic. Completion, allocation, handshake and release each
    // act only on slots in one specific registered state, so they can
    // never target the same slot in the same cycle and are applied
    // independently.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            slotState_d[i] = slotState_q[i];
        end
        allocPointer_d = allocPointer_q;
        grantPointer_d = grantPointer_q;
        slotValid_d    = slotValid_q;
        slotIndex_d    = slotIndex_q;
        releaseError_d = releaseError_q;
        goodInc        = 1'b0;
        dropInc        = 1'b0;

        // A bad pulse overrides a simultaneous good pulse for the same slot.
        for (int i = 0; i < N; i++) begin
            if (slotState_q[i] == SLOT_FILLING) begin
                if (bad_packet[i]) begin
                    slotState_d[i] = SLOT_FREE;
                    dropInc        = 1'b1;
                end else if (good_packet[i]) begin
                    slotState_d[i] = SLOT_READY;
                    goodInc        = 1'b1;
                end
            end
        end

        // Only one slot may be FILLING, so a new grant waits until the
        // previous one has retired in an earlier cycle.
        if (enable && !(|fillingMask) && allocScan[IW]) begin
            for (int i = 0; i < N; i++) begin
                if (allocScan[IW-1:0] == IW'(i)) begin
                    slotState_d[i] = SLOT_FILLING;
                end
            end
            allocPointer_d = wrapNext(allocScan[IW-1:0]);
        end

        // An offer is held until accepted; after acceptance the valid
        // drops for one cycle before the next search runs.
        if (slotValid_q) begin
            if (slot_ready) begin
                for (int i = 0; i < N; i++) begin
                    if (slotIndex_q == IW'(i)) begin
                        slotState_d[i] = SLOT_DRAINING;
                    end
                end
                grantPointer_d = wrapNext(slotIndex_q);
                slotValid_d    = 1'b0;
            end
        end else if (readyScan[IW]) begin
            slotValid_d = 1'b1;
            slotIndex_d = readyScan[IW-1:0];
        end

        // A release is only legal for a slot already DRAINING; a slot being
        // handed over in this same cycle is still READY and is rejected.
        if (slot_release) begin
            if (int'(release_index) >= N) begin
                releaseError_d = 1'b1;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (release_index == IW'(i)) begin
                        if (slotState_q[i] == SLOT_DRAINING) begin
                            slotState_d[i] = SLOT_FREE;
                        end else begin
                            releaseError_d = 1'b1;
                        end
                    end
                end
            end
        end

        // Registered status outputs reflect the state after this edge.
        for (int i = 0; i < N; i++) begin
            rxEnable_d[i]   = (slotState_d[i] == SLOT_FILLING);
            freeNextMask[i] = (slotState_d[i] == SLOT_FREE);
        end
        noSlot_d = enable && !(|rxEnable_d) && !(|freeNextMask);
    end

    // State registers. Counters are recomputed from their own value every
    // cycle so they saturate rather than wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                slotState_q[i] <= SLOT_FREE;
            end
            allocPointer_q <= '0;
            grantPointer_q <= '0;
            slotIndex_q    <= '0;
            slotValid_q    <= 1'b0;
            releaseError_q <= 1'b0;
            noSlot_q       <= 1'b0;
            rxEnable_q     <= '0;
            goodCount_q    <= '0;
            dropCount_q    <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                slotState_q[i] <= slotState_d[i];
            end
            allocPointer_q <= allocPointer_d;
            grantPointer_q <= grantPointer_d;
            slotIndex_q    <= slotIndex_d;
            slotValid_q    <= slotValid_d;
            releaseError_q <= releaseError_d;
            noSlot_q       <= noSlot_d;
            rxEnable_q     <= rxEnable_d;
            goodCount_q    <= satInc(goodCount_q, goodInc);
            dropCount_q    <= satInc(dropCount_q, dropInc);
        end
    end

    assign recieve_slot_enable  = rxEnable_q;
    assign slot_valid           = slotValid_q;
    assign slot_index           = slotIndex_q;
    assign no_slot_available    = noSlot_q;
    assign release_error        = releaseError_q;
    assign good_packet_count    = goodCount_q;
    assign dropped_packet_count = dropCount_q;

endmodule
